// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage. Owns the HI/LO registers and models
// multi-cycle latency with a down-counter. The result is computed in the
// start cycle, held in a pending register, and committed to HI/LO when the
// counter expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic        mf_sel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] LAST      = CW'(1);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic [CW-1:0]      count;
  logic [63:0]        pending;
  logic [63:0]        result;

  logic               div_zero;
  logic signed [63:0] s_prod;
  logic [63:0]        u_prod;
  logic signed [32:0] s_a;
  logic signed [32:0] s_b;
  logic [31:0]        s_quot;
  logic [31:0]        s_rem;
  logic [31:0]        u_div;
  logic [31:0]        u_quot;
  logic [31:0]        u_rem;

  // Compute the 64-bit {hi,lo} result of the E-stage operands for md_op.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    result   = {hi, lo};
    div_zero = (B == 32'd0);

    s_prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    u_prod = {32'd0, A} * {32'd0, B};

    // Signed divide is done at 33 bits so 0x80000000 / -1 yields +2^31,
    // whose low 32 bits are the required 0x80000000 with remainder 0.
    // A zero divisor is replaced by 1 only to keep the divider well defined;
    // that result is discarded in favour of the current HI/LO.
    s_a    = {A[31], A};
    s_b    = div_zero ? 33'sd1 : {B[31], B};
    s_quot = 32'(s_a / s_b);
    s_rem  = 32'(s_a % s_b);

    u_div  = div_zero ? 32'd1 : B;
    u_quot = A / u_div;
    u_rem  = A % u_div;

    case (md_op)
      OP_MULT:  result = s_prod;
      OP_MULTU: result = u_prod;
      OP_DIV:   result = div_zero ? {hi, lo} : {s_rem, s_quot};
      OP_DIVU:  result = div_zero ? {hi, lo} : {u_rem, u_quot};
      default:  result = {hi, lo};
    endcase
  end

  // Busy counter, pending result, and HI/LO updates (commit, mthi/mtlo).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the pending register is reset along with HI/LO so a discarded operation leaves no trace.
      busy    <= 1'b0;
      count   <= '0;
      pending <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (busy) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      count <= count - LAST;
      if (count == LAST) begin
        busy <= 1'b0;
        hi   <= pending[63:32];
        lo   <= pending[31:0];
      end
    end else if (start) begin
      busy    <= 1'b1;
      pending <= result;
      count   <= md_op[1] ? DIV_LOAD : MULT_LOAD;
    end else if (mt_we) begin
      if (mt_sel) lo <= A;
      else        hi <= A;
    end
  end

  assign mf_out = mf_sel ? lo : hi;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized operations
// checked against an arithmetic reference model of HI/LO.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  md_op;
  logic        mt_we;
  logic        mt_sel;
  logic        mf_sel;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_out;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .md_op   (md_op),
    .mt_we   (mt_we),
    .mt_sel  (mt_sel),
    .mf_sel  (mf_sel),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .mf_out  (mf_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural result of an md instruction given the current HI/LO.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [31:0] uq;
    logic [31:0] ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'd0) return {h, l};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'd0) return {h, l};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Issue a one-cycle start pulse; returns with one busy cycle observed.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    cycles = (busy === 1'b1) ? 1 : 0;
  endtask

  task automatic wait_idle(input string tag, inout int cycles);
    int guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (busy === 1'b1) cycles++;
    end
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic do_md(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [63:0] exp;
    int          cycles;
    exp = ref_result(op, a, b, m_hi, m_lo);
    launch(op, a, b, cycles);
    check({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
    check({tag, "_mf_old"}, {32'd0, mf_out}, {32'd0, mf_sel ? m_lo : m_hi});
    wait_idle(tag, cycles);
    check({tag, "_cycles"}, 64'(cycles), 64'(op[1] ? DIV_N : MULT_N));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic do_mt(input string tag, input logic sel, input logic [31:0] v);
    @(negedge clk);
    mt_we  = 1'b1;
    mt_sel = sel;
    A      = v;
    @(negedge clk);
    mt_we = 1'b0;
    if (sel) m_lo = v;
    else     m_hi = v;
    check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    logic [63:0] exp;
    int          cycles;

    reset_n = 1'b0;
    start   = 1'b0;
    md_op   = 2'd0;
    mt_we   = 1'b0;
    mt_sel  = 1'b0;
    mf_sel  = 1'b0;
    A       = '0;
    B       = '0;
    m_hi    = '0;
    m_lo    = '0;

    // Reset state.
    #3;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_mf", {32'd0, mf_out}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-operation discards the pending result.
    do_mt("pre_rst_mthi", 1'b0, 32'h5555_0000);
    launch(2'd0, 32'd3, 32'd4, cycles);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    repeat (10) @(negedge clk);
    check("midrst_nocommit", {hi, lo}, 64'd0);
    check("midrst_idle", {63'd0, busy}, 64'd0);

    // Directed arithmetic.
    do_md("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg_abs", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_md("multu_max", 2'd1, 32'hFFFF_FFFF, 32'd2);
    check("multu_max_abs", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    do_md("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_abs", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    do_mt("mthi_11", 1'b0, 32'h11);
    do_mt("mtlo_22", 1'b1, 32'h22);
    do_md("divu_zero", 2'd3, 32'd7, 32'd0);
    check("divu_zero_abs", {hi, lo}, 64'h0000_0011_0000_0022);
    do_md("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_abs", {hi, lo}, 64'h0000_0000_8000_0000);

    // mthi and mf readout.
    do_mt("mthi_dead", 1'b0, 32'hDEAD_BEEF);
    mf_sel = 1'b0;
    #1;
    check("mf_hi", {32'd0, mf_out}, 64'h0000_0000_DEAD_BEEF);
    mf_sel = 1'b1;
    #1;
    check("mf_lo", {32'd0, mf_out}, {32'd0, m_lo});

    // mtlo while busy is ignored.
    exp = ref_result(2'd0, 32'd3, 32'd7, m_hi, m_lo);
    launch(2'd0, 32'd3, 32'd7, cycles);
    mt_we  = 1'b1;
    mt_sel = 1'b1;
    A      = 32'hCAFE_F00D;
    @(negedge clk);
    mt_we = 1'b0;
    if (busy === 1'b1) cycles++;
    check("mt_busy_lo", {32'd0, lo}, {32'd0, m_lo});
    wait_idle("mt_busy", cycles);
    check("mt_busy_cycles", 64'(cycles), 64'(MULT_N));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    check("mt_busy_hilo", {hi, lo}, {m_hi, m_lo});

    // start and mt_we together: the operation wins, mt is dropped.
    exp = ref_result(2'd1, 32'd5, 32'd6, m_hi, m_lo);
    @(negedge clk);
    start  = 1'b1;
    md_op  = 2'd1;
    A      = 32'd5;
    B      = 32'd6;
    mt_we  = 1'b1;
    mt_sel = 1'b0;
    @(negedge clk);
    start = 1'b0;
    mt_we = 1'b0;
    cycles = (busy === 1'b1) ? 1 : 0;
    check("collide_hold", {hi, lo}, {m_hi, m_lo});
    wait_idle("collide", cycles);
    check("collide_cycles", 64'(cycles), 64'(MULT_N));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    check("collide_hilo", {hi, lo}, 64'd30);

    // A stray start while busy must not disturb the operation in flight.
    exp = ref_result(2'd2, 32'd100, 32'd7, m_hi, m_lo);
    launch(2'd2, 32'd100, 32'd7, cycles);
    start = 1'b1;
    md_op = 2'd1;
    A     = 32'hFFFF;
    B     = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    if (busy === 1'b1) cycles++;
    wait_idle("restart", cycles);
    check("restart_cycles", 64'(cycles), 64'(DIV_N));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    check("restart_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // Randomized mix of md and mt instructions.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra     = pick32();
      rb     = ($urandom_range(0, 7) == 0) ? 32'd0 : pick32();
      mf_sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 3) begin
        do_mt($sformatf("rnd%0d_mt", i), 1'($urandom_range(0, 1)), ra);
      end else begin
        do_md($sformatf("rnd%0d_md", i), 2'($urandom_range(0, 3)), ra, rb);
      end
      #1;
      check($sformatf("rnd%0d_mf", i), {32'd0, mf_out}, {32'd0, mf_sel ? m_lo : m_hi});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the P6 pipeline.
- Executes instructions that the instruction classifier tags as md (mult, multu, div, divu), mt (mthi, mtlo) and mf (mfhi, mflo).
- Owns the HI/LO architectural registers and models multi-cycle latency with a busy counter.
- The hazard unit uses this counter to stall md/mt/mf instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  E-stage instruction is md; one-cycle pulse per instruction
- md_op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled when start=1
- mt_we  input  1  E-stage instruction is mt
- mt_sel  input  1  0 mthi, 1 mtlo
- mf_sel  input  1  0 read HI, 1 read LO
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register
- mf_out  output  32  mf_sel ? lo : hi; combinational

Behaviour:
- Reset (async, reset_n=0):
  - hi, lo, busy, counter and pending result go to 0 immediately.
  - Any in-flight operation is discarded and HI/LO are not updated.
- Idle (busy=0) with start=1 at an edge:
  - Latch the computed 64-bit pending result.
  - Load counter with MULT_CYCLES or DIV_CYCLES according to md_op[1].
  - busy=1 from that edge.
- Busy:
  - counter decrements each edge.
  - On the edge where counter goes 1->0: commit pending to HI/LO and set busy=0.
  - Total: busy is high for exactly N cycles after the start edge. New HI/LO are visible, with busy=0, in the cycle after the Nth busy cycle.
- HI/LO during an operation: hold their old values until commit. mf_out reflects the old values (the hazard unit stalls mf, so this is never consumed architecturally).
- "start or busy" is the required stall condition. The unit exports busy only; the hazard unit ORs it with start.
- start while busy=1: ignored, and the operation in flight continues unaffected. Cannot occur under correct stalling; the bench flags it.
- mt_we=1, busy=0, start=0: at the edge, HI<=A (mt_sel=0) or LO<=A (mt_sel=1).
- mt_we while busy=1: ignored.
- mt_we and start in the same cycle: start wins and mt is dropped.
- Arithmetic:
  - mult: {hi,lo} = signed(A) * signed(B), full 64 bits.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (B=0) for div/divu: the operation still runs for the full DIV_CYCLES with busy, but HI/LO are left unchanged at commit.
- No other state exists. Outputs are registered, except mf_out, which is a combinational mux of registers.

Test Plan:
- Reset mid-operation: start mult A=3, B=4, wait 2 cycles, pulse reset_n low -> busy=0, hi=lo=0 immediately; no later commit.
- Signed multiply: mult A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned multiply: multu A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide: div A=-7 (0xFFFFFFF9), B=2 -> busy high exactly 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide boundaries:
  - divu 7/0 after mthi 0x11, mtlo 0x22 -> after 10 busy cycles, hi=0x11, lo=0x22.
  - div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Move and collision handling:
  - mthi A=0xDEADBEEF -> next cycle hi=0xDEADBEEF, mf_sel=0 gives mf_out=0xDEADBEEF.
  - mtlo asserted while busy -> lo unchanged.
  - start and mt_we in the same cycle -> mt dropped, operation starts.
